vend_ctrl_n: RTL and testbench
==============================

# vend_ctrl_n

Parametrised vending transaction controller: accepts single-cycle coin pulses from the coin acceptor and a one-hot item select from the keypad sequencer. It tracks credit in cents and per-item stock, and issues one-cycle dispense pulses. Change is returned automatically as paced quarter/dime/nickel pulses. It sits between the coin/keypad front-ends and the credit display decoder, and replaces the separate coin register, dispense and coin-return blocks with a single N-item engine.

## Interface
- N_ITEMS, 4, number of products (1..16)
- CREDIT_W, 8, credit register width in cents
- MAX_CREDIT, 200, credit ceiling in cents; must be ≤ 2^CREDIT_W−1
- PRICES, {4{8'd75}}, packed N_ITEMS×CREDIT_W; item i at bits [i*CREDIT_W +: CREDIT_W]; each price a nonzero multiple of 5
- STOCK_W, 4, per-item stock counter width
- STOCK_INIT, 10, stock loaded at reset and on restock
- RETURN_GAP, 4, cycles from one change pulse to the next (≥2)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- nickel, dime, quarter, dollar  in  1 each  coin pulses, one cycle
- select  in  N_ITEMS  one-hot item request pulse
- cancel  in  1  return all credit
- restock  in  1  reload all stock counters to STOCK_INIT
- credit  out  CREDIT_W  current credit, cents
- dispense  out  N_ITEMS  one-cycle vend pulse
- c_quarter, c_dime, c_nickel  out  1 each  one-cycle change pulses
- coin_reject  out  1  one-cycle pulse: the inserted coin is not credited
- deny  out  1  one-cycle pulse: select refused
- sold_out  out  N_ITEMS  stock[i]==0, combinational from registers
- busy  out  1  state != IDLE

Clock is one domain, `clk`. Reset is synchronous, active-high, `rst`.

## Operation
- States: IDLE, VEND, CHANGE.
- Reset state:
  - state IDLE
  - credit 0
  - every stock counter = STOCK_INIT
  - all pulse outputs 0; busy 0
- IDLE, coin handling:
  - Exactly one coin input high, and credit+value ≤ MAX_CREDIT: add 5/10/25/100.
  - More than one coin high, or the ceiling would be exceeded: credit unchanged, coin_reject=1.
- IDLE, select handling (only when no coin is high):
  - Multi-hot select: the lowest set index wins.
  - If stock[i]>0 and credit ≥ PRICES[i]: go to VEND.
  - Otherwise: deny=1, credit unchanged.
- IDLE, other inputs:
  - Coin and select in the same cycle: the coin is processed and the select is ignored, with no deny.
  - cancel with credit>0: go to CHANGE. cancel with credit==0: no-op.
- VEND (one cycle):
  - dispense[i]=1; credit −= PRICES[i]; stock[i] −= 1.
  - Next state: CHANGE if the remaining credit >0, else IDLE.
- CHANGE:
  - Greedy return: quarter if credit ≥25, else dime if ≥10, else nickel.
  - Each pulse decrements credit by that coin's value.
  - Pulses are spaced exactly RETURN_GAP cycles apart.
  - When credit reaches 0, go to IDLE in the cycle after the last pulse.
- Coins in VEND or CHANGE: coin_reject=1, credit unchanged.
- select and cancel in VEND or CHANGE: ignored, no deny.
- restock:
  - Honoured in any state.
  - In VEND it overrides the decrement, so the vended item's stock ends at STOCK_INIT.
- Credit never underflows: the VEND entry check and the greedy selection guarantee this. Assert it in simulation.
- All arithmetic is unsigned CREDIT_W.

## Timing
- All outputs are registered except sold_out and busy.
- A coin sampled at edge t: credit updated, or coin_reject high, in cycle t+1.
- A valid select at edge t:
  - state VEND in cycle t+1, with dispense high in t+1.
  - credit and stock take their post-vend values in t+2.
  - First change pulse in cycle t+2.
  - Subsequent change pulses at t+2+k·RETURN_GAP.
- cancel at edge t: first change pulse in cycle t+1.
- deny occurs in cycle t+1 of the refused select.
- rst mid-CHANGE or mid-VEND:
  - The next cycle is the IDLE reset state.
  - Credit is lost, with no further pulses.
  - Stock returns to STOCK_INIT.

## Structure
- `vend_defs.vh` holds:
  - coin value constants (5/10/25/100)
  - the state encodings
  - the PRICES slice macro
- Sub-module `change_pacer`:
  - RETURN_GAP down-counter plus greedy coin choice.
  - Input: credit. Outputs: pulse strobe and coin type.
  - Instantiated once in CHANGE.
- Stock counters are a generate loop in the top level.
- Elaboration checks:
  - prices are multiples of 5
  - MAX_CREDIT fits in CREDIT_W
  - RETURN_GAP ≥ 2

## Test plan
- Exact payment, price 75: quarter ×3, then select[0].
  - dispense[0] pulse, credit 0, no change pulses.
  - stock[0] goes 10→9.
- Change, price 60: dollar, then select[1].
  - dispense[1].
  - Change pulses quarter, dime, nickel at t+2, t+6, t+10 (RETURN_GAP=4).
  - credit 0; busy falls at t+11.
- Ceiling: with credit 150, insert dollar.
  - coin_reject, credit stays 150.
  - Two coins in the same cycle also give coin_reject.
- Sold out: select[2] 10 times with sufficient credit, then an 11th select.
  - Result: deny, sold_out[2]=1, credit unchanged.
  - After restock: sold_out[2]=0.
- Insufficient funds, then cancel:
  - With credit 40, select price 75: deny.
  - cancel: quarter, dime, nickel pulses, credit 0.
- Reset mid-CHANGE: assert rst after the first change pulse.
  - No further pulses; credit 0; all stock = STOCK_INIT; busy 0.

Source files
------------

// File: rtl/vend_ctrl_n_pkg.sv
// Shared constants and types for the vend_ctrl_n transaction engine.
package vend_ctrl_n_pkg;

   localparam int unsigned NickelVal  = 5;
   localparam int unsigned DimeVal    = 10;
   localparam int unsigned QuarterVal = 25;
   localparam int unsigned DollarVal  = 100;

   typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

   typedef enum logic [1:0] {CoinNickel, CoinDime, CoinQuarter} coin_e;

   // Largest coin that still fits in the amount owed.
   function automatic coin_e greedy_coin(input int unsigned cents);
      if (cents >= QuarterVal) return CoinQuarter;
      if (cents >= DimeVal) return CoinDime;
      return CoinNickel;
   endfunction

endpackage

// File: rtl/vend_ctrl_n_change_pacer.sv
// Paces change pulses RETURN_GAP cycles apart and picks the next coin greedily.
module vend_ctrl_n_change_pacer
   import vend_ctrl_n_pkg::*;
#(
   parameter int unsigned CreditW   = 8,
   parameter int unsigned ReturnGap = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               run_i,
   input  logic [CreditW-1:0] credit_i,
   output logic               fire_o,
   output coin_e              coin_o
);

   localparam int unsigned GapW = (ReturnGap > 2) ? $clog2(ReturnGap) : 1;

   logic [GapW-1:0] gap_q;

   // start_i pays out immediately; run_i waits for the gap to expire.
   assign fire_o = (credit_i != '0) && (start_i || (run_i && gap_q == '0));
   assign coin_o = greedy_coin(32'(credit_i));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gap_q <= '0;
      end else if (fire_o) begin
         gap_q <= GapW'(ReturnGap - 1);
      end else if (gap_q != '0) begin
         gap_q <= gap_q - GapW'(1);
      end
   end

endmodule

// File: rtl/vend_ctrl_n.sv
// N-item vending engine: coin credit, per-item stock, vend pulses and paced change return.
module vend_ctrl_n
   import vend_ctrl_n_pkg::*;
#(
   parameter int unsigned                      N_ITEMS    = 4,
   parameter int unsigned                      CREDIT_W   = 8,
   parameter int unsigned                      MAX_CREDIT = 200,
   parameter logic [N_ITEMS*CREDIT_W-1:0]      PRICES     = {4{8'd75}},
   parameter int unsigned                      STOCK_W    = 4,
   parameter int unsigned                      STOCK_INIT = 10,
   parameter int unsigned                      RETURN_GAP = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                nickel,
   input  logic                dime,
   input  logic                quarter,
   input  logic                dollar,
   input  logic [N_ITEMS-1:0]  select,
   input  logic                cancel,
   input  logic                restock,
   output logic [CREDIT_W-1:0] credit,
   output logic [N_ITEMS-1:0]  dispense,
   output logic                c_quarter,
   output logic                c_dime,
   output logic                c_nickel,
   output logic                coin_reject,
   output logic                deny,
   output logic [N_ITEMS-1:0]  sold_out,
   output logic                busy
);

   localparam int unsigned IdxW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
   localparam int unsigned SumW = CREDIT_W + 1;

   if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_bad_max
      $error("MAX_CREDIT does not fit in CREDIT_W");
   end
   if (RETURN_GAP < 2) begin : g_bad_gap
      $error("RETURN_GAP must be at least 2");
   end

   state_e              state_q;
   logic [CREDIT_W-1:0] credit_q;
   logic [IdxW-1:0]     vend_idx_q;
   logic [N_ITEMS-1:0]  dispense_q;
   logic                c_quarter_q, c_dime_q, c_nickel_q;
   logic                coin_reject_q, deny_q;

   logic [CREDIT_W-1:0] price [N_ITEMS];
   logic [STOCK_W-1:0]  stock [N_ITEMS];

   logic                any_coin, one_coin, coin_ok;
   logic [SumW-1:0]     coin_val, coin_sum;
   logic [IdxW-1:0]     sel_idx;
   logic                sel_any, sel_ok;
   logic [CREDIT_W-1:0] pay_credit, pulse_val, change_left;
   logic                pacer_start, fire;
   coin_e               fire_coin;

   for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
      logic [STOCK_W-1:0] cnt_q;

      if ((PRICES[i*CREDIT_W +: CREDIT_W] % 5) != 0 || PRICES[i*CREDIT_W +: CREDIT_W] == '0)
      begin : g_bad_price
         $error("item price must be a nonzero multiple of 5");
      end

      assign price[i]    = PRICES[i*CREDIT_W +: CREDIT_W];
      assign stock[i]    = cnt_q;
      assign sold_out[i] = (cnt_q == '0);

      // Restock wins over the vend decrement.
      always_ff @(posedge clk) begin
         if (rst || restock) begin
            cnt_q <= STOCK_W'(STOCK_INIT);
         end else if (state_q == StVend && vend_idx_q == IdxW'(i)) begin
            cnt_q <= cnt_q - STOCK_W'(1);
         end
      end
   end

   assign any_coin = nickel | dime | quarter | dollar;
   assign one_coin = ($countones({nickel, dime, quarter, dollar}) == 1);

   always_comb begin
      coin_val = '0;
      if (nickel)  coin_val = SumW'(NickelVal);
      if (dime)    coin_val = SumW'(DimeVal);
      if (quarter) coin_val = SumW'(QuarterVal);
      if (dollar)  coin_val = SumW'(DollarVal);
   end

   assign coin_sum = {1'b0, credit_q} + coin_val;
   assign coin_ok  = one_coin && (coin_sum <= SumW'(MAX_CREDIT));

   always_comb begin
      sel_idx = '0;
      for (int i = int'(N_ITEMS) - 1; i >= 0; i--) begin
         if (select[i]) sel_idx = IdxW'(i);
      end
   end

   assign sel_any = |select;
   assign sel_ok  = (stock[sel_idx] != '0) && (credit_q >= price[sel_idx]);

   // Change pulses are subtracted on the edge that ends the pulse cycle.
   always_comb begin
      pulse_val = '0;
      if (c_quarter_q)   pulse_val = CREDIT_W'(QuarterVal);
      else if (c_dime_q) pulse_val = CREDIT_W'(DimeVal);
      else if (c_nickel_q) pulse_val = CREDIT_W'(NickelVal);
   end

   assign change_left = credit_q - pulse_val;
   assign pay_credit  = (state_q == StVend) ? credit_q - price[vend_idx_q] : credit_q;
   assign pacer_start = (state_q == StVend) || (state_q == StIdle && !any_coin && cancel);

   vend_ctrl_n_change_pacer #(
      .CreditW   (CREDIT_W),
      .ReturnGap (RETURN_GAP)
   ) u_pacer (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (pacer_start),
      .run_i    (state_q == StChange),
      .credit_i (pay_credit),
      .fire_o   (fire),
      .coin_o   (fire_coin)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         credit_q      <= '0;
         vend_idx_q    <= '0;
         dispense_q    <= '0;
         c_quarter_q   <= 1'b0;
         c_dime_q      <= 1'b0;
         c_nickel_q    <= 1'b0;
         coin_reject_q <= 1'b0;
         deny_q        <= 1'b0;
      end else begin
         dispense_q    <= '0;
         c_quarter_q   <= 1'b0;
         c_dime_q      <= 1'b0;
         c_nickel_q    <= 1'b0;
         coin_reject_q <= any_coin && (state_q != StIdle || !coin_ok);
         deny_q        <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (any_coin) begin
                  if (coin_ok) credit_q <= coin_sum[CREDIT_W-1:0];
               end else if (cancel) begin
                  if (credit_q != '0) state_q <= StChange;
               end else if (sel_any) begin
                  if (sel_ok) begin
                     state_q             <= StVend;
                     vend_idx_q          <= sel_idx;
                     dispense_q[sel_idx] <= 1'b1;
                  end else begin
                     deny_q <= 1'b1;
                  end
               end
            end
            StVend: begin
               credit_q <= pay_credit;
               state_q  <= (pay_credit != '0) ? StChange : StIdle;
            end
            StChange: begin
               credit_q <= change_left;
               if (change_left == '0) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
         if (fire) begin
            c_quarter_q <= (fire_coin == CoinQuarter);
            c_dime_q    <= (fire_coin == CoinDime);
            c_nickel_q  <= (fire_coin == CoinNickel);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && state_q == StVend) begin
         assert (credit_q >= price[vend_idx_q]) else $error("credit underflow on vend");
      end
      if (!rst && state_q == StChange) begin
         assert (credit_q >= pulse_val) else $error("credit underflow on change");
      end
   end

   assign credit      = credit_q;
   assign dispense    = dispense_q;
   assign c_quarter   = c_quarter_q;
   assign c_dime      = c_dime_q;
   assign c_nickel    = c_nickel_q;
   assign coin_reject = coin_reject_q;
   assign deny        = deny_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_vend_ctrl_n.sv
// Scoreboard bench for vend_ctrl_n: expected pulse events are queued with their cycle.
module tb_vend_ctrl_n;

   localparam logic [8:0] EvQ    = 9'h010;
   localparam logic [8:0] EvD    = 9'h008;
   localparam logic [8:0] EvN    = 9'h004;
   localparam logic [8:0] EvRej  = 9'h002;
   localparam logic [8:0] EvDeny = 9'h001;
   // coin vectors are {dollar, quarter, dime, nickel}
   localparam logic [3:0] CN = 4'b0001;
   localparam logic [3:0] CD = 4'b0010;
   localparam logic [3:0] CQ = 4'b0100;
   localparam logic [3:0] CL = 4'b1000;

   logic       clk = 1'b0;
   logic       rst, nickel, dime, quarter, dollar, cancel, restock;
   logic [3:0] select, dispense, sold_out;
   logic [7:0] credit;
   logic       c_quarter, c_dime, c_nickel, coin_reject, deny, busy;

   vend_ctrl_n #(
      .N_ITEMS    (4),
      .CREDIT_W   (8),
      .MAX_CREDIT (200),
      .PRICES     ({8'd50, 8'd25, 8'd60, 8'd75}),
      .STOCK_W    (4),
      .STOCK_INIT (10),
      .RETURN_GAP (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .nickel      (nickel),
      .dime        (dime),
      .quarter     (quarter),
      .dollar      (dollar),
      .select      (select),
      .cancel      (cancel),
      .restock     (restock),
      .credit      (credit),
      .dispense    (dispense),
      .c_quarter   (c_quarter),
      .c_dime      (c_dime),
      .c_nickel    (c_nickel),
      .coin_reject (coin_reject),
      .deny        (deny),
      .sold_out    (sold_out),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int         cyc;
      string      tag;
      logic [8:0] ev;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_on = 1'b0;
   int   t;
   int   c0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic void expect_ev(input int c, input string tag, input logic [8:0] e);
      exp_t x;
      x.cyc = c;
      x.tag = tag;
      x.ev  = e;
      exp_q.push_back(x);
   endfunction

   always @(negedge clk) begin
      exp_t       e;
      logic [8:0] ev;
      if (mon_on) begin
         ev = {dispense, c_quarter, c_dime, c_nickel, coin_reject, deny};
         if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check_eq(e.tag, ev, e.ev);
         end else if (ev != 9'd0) begin
            check_eq("stray_event", ev, 9'd0);
         end
      end
   end

   // Inputs are set at a falling edge, sampled at the next rising edge (end of cycle t).
   task automatic apply(input logic [3:0] coins, input logic [3:0] sel, input logic can,
                        input logic rs);
      {dollar, quarter, dime, nickel} = coins;
      select  = sel;
      cancel  = can;
      restock = rs;
      t = cyc;
      @(negedge clk);
      {dollar, quarter, dime, nickel} = 4'b0;
      select  = 4'b0;
      cancel  = 1'b0;
      restock = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic buy_item2(input int n);
      for (int k = 0; k < n; k++) begin
         apply(CQ, 4'b0, 1'b0, 1'b0);
         expect_ev(cyc + 1, "vend_item2", {4'b0100, 5'b0});
         apply(4'b0, 4'b0100, 1'b0, 1'b0);
         wait_cyc(t + 2);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation ran past its time budget");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      {dollar, quarter, dime, nickel} = 4'b0;
      select  = 4'b0;
      cancel  = 1'b0;
      restock = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b0;
      mon_on = 1'b1;
      check_eq("reset_credit", credit, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_sold_out", sold_out, 0);
      check_eq("reset_pulses", {dispense, c_quarter, c_dime, c_nickel, coin_reject, deny}, 0);

      // exact payment for item 0 (75)
      apply(CQ, 4'b0, 1'b0, 1'b0); check_eq("credit_25", credit, 25);
      apply(CQ, 4'b0, 1'b0, 1'b0); check_eq("credit_50", credit, 50);
      apply(CQ, 4'b0, 1'b0, 1'b0); check_eq("credit_75", credit, 75);
      expect_ev(cyc + 1, "vend_item0", {4'b0001, 5'b0});
      apply(4'b0, 4'b0001, 1'b0, 1'b0);
      check_eq("busy_in_vend", busy, 1);
      wait_cyc(t + 2);
      check_eq("exact_credit", credit, 0);
      check_eq("exact_idle", busy, 0);

      // dollar for item 1 (60): change 25, 10, 5
      apply(CL, 4'b0, 1'b0, 1'b0); check_eq("credit_100", credit, 100);
      c0 = cyc;
      expect_ev(c0 + 1, "vend_item1", {4'b0010, 5'b0});
      expect_ev(c0 + 2, "change_quarter", EvQ);
      expect_ev(c0 + 6, "change_dime", EvD);
      expect_ev(c0 + 10, "change_nickel", EvN);
      apply(4'b0, 4'b0010, 1'b0, 1'b0);
      wait_cyc(c0 + 2);  check_eq("post_vend_credit", credit, 40);
      wait_cyc(c0 + 10); check_eq("busy_last_pulse", busy, 1);
      wait_cyc(c0 + 11);
      check_eq("change_done_busy", busy, 0);
      check_eq("change_done_credit", credit, 0);

      // credit ceiling and double coin
      apply(CL, 4'b0, 1'b0, 1'b0);
      apply(CQ, 4'b0, 1'b0, 1'b0);
      apply(CQ, 4'b0, 1'b0, 1'b0); check_eq("credit_150", credit, 150);
      expect_ev(cyc + 1, "reject_ceiling", EvRej);
      apply(CL, 4'b0, 1'b0, 1'b0); check_eq("ceiling_credit", credit, 150);
      expect_ev(cyc + 1, "reject_two_coins", EvRej);
      apply(CD | CN, 4'b0, 1'b0, 1'b0); check_eq("two_coin_credit", credit, 150);

      // cancel 150: six quarters; a coin and select during change
      c0 = cyc;
      expect_ev(c0 + 1, "cancel_quarter", EvQ);
      expect_ev(c0 + 2, "reject_in_change", EvRej);
      for (int k = 1; k < 6; k++) expect_ev(c0 + 1 + 4 * k, "cancel_quarter", EvQ);
      apply(4'b0, 4'b0, 1'b1, 1'b0);
      apply(CN, 4'b0001, 1'b0, 1'b0);
      check_eq("credit_during_change", credit, 125);
      wait_cyc(c0 + 22);
      check_eq("cancel150_credit", credit, 0);
      check_eq("cancel150_busy", busy, 0);

      // coin with select: coin wins, no deny; then insufficient funds
      apply(CQ, 4'b0001, 1'b0, 1'b0); check_eq("coin_beats_select", credit, 25);
      apply(CD, 4'b0, 1'b0, 1'b0);
      apply(CN, 4'b0, 1'b0, 1'b0); check_eq("credit_40", credit, 40);
      expect_ev(cyc + 1, "deny_funds", EvDeny);
      apply(4'b0, 4'b0001, 1'b0, 1'b0); check_eq("deny_credit", credit, 40);
      c0 = cyc;
      expect_ev(c0 + 1, "cancel40_quarter", EvQ);
      expect_ev(c0 + 5, "cancel40_dime", EvD);
      expect_ev(c0 + 9, "cancel40_nickel", EvN);
      apply(4'b0, 4'b0, 1'b1, 1'b0);
      wait_cyc(c0 + 10);
      check_eq("cancel40_credit", credit, 0);
      check_eq("cancel40_busy", busy, 0);

      // multi-hot select: lowest index (item 1, 60) wins
      apply(CQ, 4'b0, 1'b0, 1'b0);
      apply(CQ, 4'b0, 1'b0, 1'b0);
      apply(CD, 4'b0, 1'b0, 1'b0);
      expect_ev(cyc + 1, "multihot_vend1", {4'b0010, 5'b0});
      apply(4'b0, 4'b1010, 1'b0, 1'b0);
      wait_cyc(t + 2); check_eq("multihot_credit", credit, 0);

      // sell out item 2, deny, restock
      buy_item2(10);
      check_eq("sold_out_item2", sold_out, 4'b0100);
      apply(CQ, 4'b0, 1'b0, 1'b0);
      expect_ev(cyc + 1, "deny_sold_out", EvDeny);
      apply(4'b0, 4'b0100, 1'b0, 1'b0);
      check_eq("sold_out_credit", credit, 25);
      check_eq("sold_out_still", sold_out, 4'b0100);
      apply(4'b0, 4'b0, 1'b0, 1'b1);
      check_eq("restock_clears", sold_out, 4'b0000);
      c0 = cyc;
      expect_ev(c0 + 1, "cancel25_quarter", EvQ);
      apply(4'b0, 4'b0, 1'b1, 1'b0);
      wait_cyc(c0 + 2); check_eq("cancel25_credit", credit, 0);

      // sell out again, then reset in the middle of change
      buy_item2(10);
      check_eq("sold_out_again", sold_out, 4'b0100);
      apply(CL, 4'b0, 1'b0, 1'b0);
      c0 = cyc;
      expect_ev(c0 + 1, "pre_reset_quarter", EvQ);
      apply(4'b0, 4'b0, 1'b1, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("rst_mid_credit", credit, 0);
      check_eq("rst_mid_busy", busy, 0);
      check_eq("rst_mid_stock", sold_out, 4'b0000);
      wait_cyc(c0 + 14);

      check_eq("pending_expectations", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
